// File: rtl/ram_rd_stream.sv
// Read-side streaming adapter for one port of a synchronous RAM: valid/ready
// request channel in, valid/ready response channel out, credit-counted skid buffer.
module ram_rd_stream #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_REGS   = 0,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  ReqValid_SI,
  output logic                  ReqReady_SO,
  input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
  output logic                  RspValid_SO,
  input  logic                  RspReady_SI,
  output logic [DATA_WIDTH-1:0] RspData_DO,
  output logic                  RamCSel_SO,
  output logic [ADDR_WIDTH-1:0] RamAddr_DO,
  input  logic [DATA_WIDTH-1:0] RamRdData_DI,
  output logic                  Idle_SO
);

  localparam int unsigned LAT   = OUT_REGS + 1;
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);

  if (OUT_REGS > 1) begin : g_bad_out_regs
    $error("ram_rd_stream: OUT_REGS must be 0 or 1");
  end
  if ((BUF_DEPTH < 2) || ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ram_rd_stream: BUF_DEPTH must be a power of two >= 2");
  end

  logic [CNT_W-1:0]      cnt_q;
  logic [LAT-1:0]        vld_q;
  logic [PTR_W:0]        wr_ptr_q;
  logic [PTR_W:0]        rd_ptr_q;
  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];

  logic accept;
  logic pop;

  // Credits cover in-flight reads too, so a read is only issued when its
  // data is guaranteed a buffer slot; the RAM output itself cannot stall.
  assign ReqReady_SO = (cnt_q < CNT_MAX);
  assign accept      = ReqValid_SI & ReqReady_SO;
  assign RamCSel_SO  = accept;
  assign RamAddr_DO  = ReqAddr_DI;

  assign RspValid_SO = (wr_ptr_q != rd_ptr_q);
  assign pop         = RspValid_SO & RspReady_SI;
  assign RspData_DO  = RspValid_SO ? buf_q[rd_ptr_q[PTR_W-1:0]] : '0;
  assign Idle_SO     = (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      cnt_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase

      vld_q[0] <= accept;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end

      if (vld_q[LAT-1]) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // NOTE: the data array has no reset; the reset pointers already mark every
  // entry empty, so clearing the storage would only add reset fan-out.
  always_ff @(posedge Clk_CI) begin
    if (vld_q[LAT-1]) begin
      buf_q[wr_ptr_q[PTR_W-1:0]] <= RamRdData_DI;
    end
  end

  logic [PTR_W:0] occupancy;
  assign occupancy = wr_ptr_q - rd_ptr_q;

  a_cnt_bound : assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
    cnt_q <= CNT_MAX);
  a_occ_bound : assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
    occupancy <= CNT_MAX);

endmodule

// File: tb/tb_ram_rd_stream.sv
// Bench for ram_rd_stream: one instance with read latency 1 and one with latency 2,
// sharing stimulus, each behind its own behavioural RAM.
module tb_ram_rd_stream;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        rsp_ready;
  logic [9:0]  req_addr;

  logic        rr0, rv0, cs0, idle0;
  logic [31:0] rd0, ram0;
  logic [9:0]  ra0;
  logic        rr1, rv1, cs1, idle1;
  logic [31:0] rd1, ram1, ram1_s;
  logic [9:0]  ra1;

  int n_total = 0;
  int n_bad   = 0;

  function automatic logic [31:0] mem_val(input logic [9:0] a);
    return {16'hA5A5, 6'd0, a};
  endfunction

  ram_rd_stream #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .OUT_REGS(0), .BUF_DEPTH(4)) u_dut0 (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .ReqValid_SI(req_valid), .ReqReady_SO(rr0), .ReqAddr_DI(req_addr),
    .RspValid_SO(rv0), .RspReady_SI(rsp_ready), .RspData_DO(rd0),
    .RamCSel_SO(cs0), .RamAddr_DO(ra0), .RamRdData_DI(ram0), .Idle_SO(idle0)
  );

  ram_rd_stream #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .OUT_REGS(1), .BUF_DEPTH(4)) u_dut1 (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .ReqValid_SI(req_valid), .ReqReady_SO(rr1), .ReqAddr_DI(req_addr),
    .RspValid_SO(rv1), .RspReady_SI(rsp_ready), .RspData_DO(rd1),
    .RamCSel_SO(cs1), .RamAddr_DO(ra1), .RamRdData_DI(ram1), .Idle_SO(idle1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAMs: no reset, so stale read data keeps flowing after a reset.
  always @(posedge clk) begin
    if (cs0) ram0 <= mem_val(ra0);
    if (cs1) ram1_s <= mem_val(ra1);
    ram1 <= ram1_s;
  end

  // Reference model: per instance a latency pipe, a response FIFO and a credit count.
  logic [9:0] mq0[$];
  logic [9:0] mq1[$];
  logic       p0_v, p1_v0, p1_v1;
  logic [9:0] p0_a, p1_a0, p1_a1;
  int         mc0, mc1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq0.delete(); mq1.delete();
      p0_v = 1'b0; p1_v0 = 1'b0; p1_v1 = 1'b0;
      mc0 = 0; mc1 = 0;
    end else begin
      automatic bit acc0 = req_valid && (mc0 < 4);
      automatic bit pop0 = (mq0.size() != 0) && rsp_ready;
      automatic bit acc1 = req_valid && (mc1 < 4);
      automatic bit pop1 = (mq1.size() != 0) && rsp_ready;
      if (pop0) void'(mq0.pop_front());
      if (p0_v) mq0.push_back(p0_a);
      p0_v = acc0; p0_a = req_addr;
      mc0 = mc0 + int'(acc0) - int'(pop0);
      if (pop1) void'(mq1.pop_front());
      if (p1_v1) mq1.push_back(p1_a1);
      p1_v1 = p1_v0; p1_a1 = p1_a0;
      p1_v0 = acc1;  p1_a0 = req_addr;
      mc1 = mc1 + int'(acc1) - int'(pop1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '0;
    @(negedge clk);
    if ({rr0, rv0, rd0, idle0} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
      n_bad++; $display("FAIL reset_dut0 got rr=%b rv=%b rd=%h idle=%b exp 1 0 0 1", rr0, rv0, rd0, idle0);
    end
    n_total++;
    if ({rr1, rv1, rd1, idle1} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
      n_bad++; $display("FAIL reset_dut1 got rr=%b rv=%b rd=%h idle=%b exp 1 0 0 1", rr1, rv1, rd1, idle1);
    end
    n_total++;
    req_valid = 1'b1;
    #1;
    if ({cs0, cs1} !== 2'b11) begin
      n_bad++; $display("FAIL reset_csel got %b%b exp 11", cs0, cs1);
    end
    n_total++;
    req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    if ({rr0, rv0, rd0, idle0, cs0} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL post_reset_dut0 got rr=%b rv=%b rd=%h idle=%b cs=%b", rr0, rv0, rd0, idle0, cs0);
    end
    n_total++;
  endtask

  task automatic test_single();
    tick(); req_valid = 1'b1; req_addr = 10'd5;
    @(negedge clk);
    if ({cs0, cs1} !== 2'b11 || ra0 !== 10'd5 || ra1 !== 10'd5) begin
      n_bad++; $display("FAIL single_issue got cs=%b%b addr=%0d/%0d exp cs=11 addr=5", cs0, cs1, ra0, ra1);
    end
    n_total++;
    tick(); req_valid = 1'b0;
    @(negedge clk);
    if (rv0 !== 1'b0 || idle0 !== 1'b0) begin
      n_bad++; $display("FAIL single_c1_dut0 got rv=%b idle=%b exp rv=0 idle=0", rv0, idle0);
    end
    n_total++;
    tick(); rsp_ready = 1'b1;
    @(negedge clk);
    if (rv0 !== 1'b1 || rd0 !== 32'hA5A5_0005 || rv1 !== 1'b0) begin
      n_bad++; $display("FAIL single_c2 got rv0=%b rd0=%h rv1=%b exp 1 a5a50005 0", rv0, rd0, rv1);
    end
    n_total++;
    tick();
    @(negedge clk);
    if (rv0 !== 1'b0 || idle0 !== 1'b1 || rv1 !== 1'b1 || rd1 !== 32'hA5A5_0005) begin
      n_bad++; $display("FAIL single_c3 got rv0=%b idle0=%b rv1=%b rd1=%h exp 0 1 1 a5a50005", rv0, idle0, rv1, rd1);
    end
    n_total++;
    tick();
    @(negedge clk);
    if (rv1 !== 1'b0 || idle1 !== 1'b1) begin
      n_bad++; $display("FAIL single_c4_dut1 got rv=%b idle=%b exp 0 1", rv1, idle1);
    end
    n_total++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_stream();
    for (int c = 0; c <= 20; c++) begin
      automatic bit          ev0, ev1;
      automatic logic [31:0] ed0, ed1;
      tick();
      req_valid = (c < 16); req_addr = 10'(c); rsp_ready = 1'b1;
      @(negedge clk);
      ev0 = (c >= 2) && (c <= 17);
      ev1 = (c >= 3) && (c <= 18);
      ed0 = ev0 ? mem_val(10'(c - 2)) : 32'h0;
      ed1 = ev1 ? mem_val(10'(c - 3)) : 32'h0;
      if (c < 16) begin
        if ({rr0, rr1} !== 2'b11) begin
          n_bad++; $display("FAIL stream_ready c=%0d got %b%b exp 11", c, rr0, rr1);
        end
        n_total++;
      end
      if (rv0 !== ev0 || rd0 !== ed0) begin
        n_bad++; $display("FAIL stream_dut0 c=%0d got rv=%b rd=%h exp rv=%b rd=%h", c, rv0, rd0, ev0, ed0);
      end
      n_total++;
      if (rv1 !== ev1 || rd1 !== ed1) begin
        n_bad++; $display("FAIL stream_dut1 c=%0d got rv=%b rd=%h exp rv=%b rd=%h", c, rv1, rd1, ev1, ed1);
      end
      n_total++;
    end
    if ({idle0, idle1} !== 2'b11) begin
      n_bad++; $display("FAIL stream_idle got %b%b exp 11", idle0, idle1);
    end
    n_total++;
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 8; c++) begin
      automatic bit exp_rdy = (c < 4);
      tick();
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = (c < 4) ? 10'(32 + c) : 10'd36;
      @(negedge clk);
      if (rr0 !== exp_rdy || cs0 !== exp_rdy || rr1 !== exp_rdy || cs1 !== exp_rdy) begin
        n_bad++; $display("FAIL bp_ready c=%0d got rr=%b%b cs=%b%b exp %b", c, rr0, rr1, cs0, cs1, exp_rdy);
      end
      n_total++;
      if (rv0 !== (c >= 2) || rd0 !== ((c >= 2) ? mem_val(10'd32) : 32'h0)) begin
        n_bad++; $display("FAIL bp_hold_dut0 c=%0d got rv=%b rd=%h", c, rv0, rd0);
      end
      n_total++;
      if (rv1 !== (c >= 3) || rd1 !== ((c >= 3) ? mem_val(10'd32) : 32'h0)) begin
        n_bad++; $display("FAIL bp_hold_dut1 c=%0d got rv=%b rd=%h", c, rv1, rd1);
      end
      n_total++;
    end
  endtask

  task automatic test_full_boundary();
    int idx0 = 0;
    int idx1 = 0;
    tick(); rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 10'd36;
    @(negedge clk);
    if ({rr0, cs0, rr1, cs1} !== 4'b0000 || rd0 !== mem_val(10'd32) || rd1 !== mem_val(10'd32)) begin
      n_bad++; $display("FAIL full_pop_cycle got rr/cs=%b%b%b%b rd=%h/%h exp 0000 a5a50020", rr0, cs0, rr1, cs1, rd0, rd1);
    end
    n_total++;
    tick(); rsp_ready = 1'b0;
    @(negedge clk);
    if ({rr0, cs0, rr1, cs1} !== 4'b1111 || rd0 !== mem_val(10'd33) || rd1 !== mem_val(10'd33)) begin
      n_bad++; $display("FAIL full_next_cycle got rr/cs=%b%b%b%b rd=%h/%h exp 1111 a5a50021", rr0, cs0, rr1, cs1, rd0, rd1);
    end
    n_total++;
    tick(); req_addr = 10'd37;
    @(negedge clk);
    if ({rr0, cs0, rr1, cs1} !== 4'b0000) begin
      n_bad++; $display("FAIL full_refilled got rr/cs=%b%b%b%b exp 0000", rr0, cs0, rr1, cs1);
    end
    n_total++;
    for (int i = 0; i < 12; i++) begin
      tick(); req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      if (rv0) begin
        if (idx0 >= 4 || rd0 !== mem_val(10'(33 + idx0))) begin
          n_bad++; $display("FAIL drain_dut0 idx=%0d got %h exp %h", idx0, rd0, mem_val(10'(33 + idx0)));
        end
        n_total++;
        idx0++;
      end
      if (rv1) begin
        if (idx1 >= 4 || rd1 !== mem_val(10'(33 + idx1))) begin
          n_bad++; $display("FAIL drain_dut1 idx=%0d got %h exp %h", idx1, rd1, mem_val(10'(33 + idx1)));
        end
        n_total++;
        idx1++;
      end
    end
    if (idx0 != 4 || idx1 != 4 || {idle0, idle1} !== 2'b11) begin
      n_bad++; $display("FAIL drain_count got %0d/%0d idle=%b%b exp 4/4 idle=11", idx0, idx1, idle0, idle1);
    end
    n_total++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick(); req_valid = 1'b1; req_addr = 10'd7;
    tick(); req_addr = 10'd8;
    tick(); req_valid = 1'b0; rsp_ready = 1'b0; rst_n = 1'b0;
    #1;
    if ({rv0, rv1, idle0, idle1, rr0, rr1} !== 6'b001111 || rd0 !== 32'h0 || rd1 !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid_async got rv=%b%b idle=%b%b rr=%b%b rd=%h/%h", rv0, rv1, idle0, idle1, rr0, rr1, rd0, rd1);
    end
    n_total++;
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      if ({rv0, rv1, idle0, idle1} !== 4'b0011) begin
        n_bad++; $display("FAIL rst_mid_ghost i=%0d got rv=%b%b idle=%b%b exp 00 11", i, rv0, rv1, idle0, idle1);
      end
      n_total++;
    end
    tick(); req_valid = 1'b1; req_addr = 10'd9; rsp_ready = 1'b1;
    @(negedge clk);
    if ({cs0, cs1} !== 2'b11) begin
      n_bad++; $display("FAIL rst_mid_reissue got cs=%b%b exp 11", cs0, cs1);
    end
    n_total++;
    tick(); req_valid = 1'b0;
    @(negedge clk);
    if ({rv0, rv1} !== 2'b00) begin
      n_bad++; $display("FAIL rst_mid_c1 got rv=%b%b exp 00", rv0, rv1);
    end
    n_total++;
    tick();
    @(negedge clk);
    if (rv0 !== 1'b1 || rd0 !== mem_val(10'd9) || rv1 !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_c2 got rv0=%b rd0=%h rv1=%b exp 1 a5a50009 0", rv0, rd0, rv1);
    end
    n_total++;
    tick();
    @(negedge clk);
    if (rv1 !== 1'b1 || rd1 !== mem_val(10'd9) || idle0 !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_c3 got rv1=%b rd1=%h idle0=%b exp 1 a5a50009 1", rv1, rd1, idle0);
    end
    n_total++;
    tick();
    @(negedge clk);
    if (idle1 !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_idle1 got %b exp 1", idle1);
    end
    n_total++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      automatic logic [31:0] ed0, ed1;
      tick();
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = 10'($urandom_range(0, 1023));
      rsp_ready = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      ed0 = (mq0.size() != 0) ? mem_val(mq0[0]) : 32'h0;
      ed1 = (mq1.size() != 0) ? mem_val(mq1[0]) : 32'h0;
      if (rr0 !== (mc0 < 4) || cs0 !== (req_valid && mc0 < 4) || idle0 !== (mc0 == 0) ||
          rv0 !== (mq0.size() != 0) || rd0 !== ed0) begin
        n_bad++; $display("FAIL rand_dut0 c=%0d got rr=%b cs=%b idle=%b rv=%b rd=%h exp cnt=%0d q=%0d rd=%h",
                          c, rr0, cs0, idle0, rv0, rd0, mc0, mq0.size(), ed0);
      end
      n_total++;
      if (rr1 !== (mc1 < 4) || cs1 !== (req_valid && mc1 < 4) || idle1 !== (mc1 == 0) ||
          rv1 !== (mq1.size() != 0) || rd1 !== ed1) begin
        n_bad++; $display("FAIL rand_dut1 c=%0d got rr=%b cs=%b idle=%b rv=%b rd=%h exp cnt=%0d q=%0d rd=%h",
                          c, rr1, cs1, idle1, rv1, rd1, mc1, mq1.size(), ed1);
      end
      n_total++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_full_boundary();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
